pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 12, program-counter width in bits.
REQ-002 Parameter EXC_VEC, default 12'hF00, exception handler address.
REQ-003 Parameter RESET_PC, default 12'h000, PC value loaded by reset.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 clr_n  input  1  reset, synchronous, active-low.
REQ-006 stall  input  1  hold PC and state this cycle.
REQ-007 br_taken  input  1  conditional branch resolved taken.
REQ-008 br_offset  input  PC_W  two's-complement branch offset.
REQ-009 jump  input  1  absolute jump (j/jal).
REQ-010 jump_target  input  PC_W  absolute jump address.
REQ-011 jr  input  1  register-indirect jump.
REQ-012 jr_target  input  PC_W  register jump address.
REQ-013 exc  input  1  exception request.
REQ-014 halt  input  1  halt request.
REQ-015 pc  output  PC_W  current fetch address.
REQ-016 pc_plus1  output  PC_W  pc+1 modulo 2^PC_W, combinational.
REQ-017 epc  output  PC_W  PC of the instruction that took the last exception.
REQ-018 fetch_valid  output  1  pc is a valid fetch address this cycle.
REQ-019 redirect  output  1  pc was loaded non-sequentially at the previous edge (flush request).
REQ-020 halted  output  1  sequencer is in HALT.

Function
REQ-021 FSM states SHALL be BOOT, RUN and HALT.
REQ-022 BOOT: fetch_valid=0; all control inputs ignored; next state RUN unconditionally; pc unchanged.
REQ-023 RUN: fetch_valid=1; next pc chosen at each edge with strict priority exc > stall > halt > jr > jump > br_taken > sequential.
REQ-024 exc in RUN: epc <= pc, pc <= EXC_VEC, redirect=1 next cycle; exc overrides stall and halt in the same cycle.
REQ-025 stall in RUN (no exc): pc, epc and state held; redirect=0 next cycle.
REQ-026 halt in RUN (no exc, no stall): state <= HALT, pc held.
REQ-027 jr: pc <= jr_target; jump: pc <= jump_target; br_taken: pc <= pc+1+br_offset; each sets redirect=1 next cycle.
REQ-028 Sequential: pc <= pc+1; redirect=0 next cycle.
REQ-029 All PC arithmetic SHALL be modulo 2^PC_W; 12'hFFF+1 wraps to 12'h000 with no flag.
REQ-030 HALT: fetch_valid=0, halted=1, pc and epc frozen, all inputs including exc ignored; exit only via reset.
REQ-031 Latency: an input sampled at edge N SHALL be reflected on pc immediately after edge N (one-cycle).
REQ-032 redirect SHALL be a registered single-cycle pulse per non-sequential load.

Reset
REQ-033 When clr_n=0 at a rising edge: state <= BOOT, pc <= RESET_PC, epc <= 0, redirect <= 0.
REQ-034 Outputs after reset edge: fetch_valid=0, halted=0, pc_plus1=RESET_PC+1.
REQ-035 Reset SHALL take precedence over every other input and apply from any state, including mid-stall and HALT.
REQ-036 Without a reset edge, power-up state is undefined; no initial blocks SHALL be relied on.

Structure
REQ-037 Shared package pc_seq_pkg SHALL hold the state encoding, PC_W, EXC_VEC and RESET_PC defaults.
REQ-038 The PC storage SHALL be a sub-module pc_reg: PC_W-bit register with load enable and synchronous active-low clear to RESET_PC.
REQ-039 Next-PC mux and FSM SHALL reside in pc_sequencer; no latches, no combinational loops.

Verification
REQ-040 Reset then 4 idle cycles -> BOOT one cycle (fetch_valid=0, pc=000), then pc=000,001,002,003 with fetch_valid=1.
REQ-041 pc=010, br_taken=1, br_offset=12'hFFE -> pc=00F next, redirect=1 one cycle; jump and br_taken together with jump_target=0A0 -> pc=0A0.
REQ-042 pc=020, stall=1 three cycles -> pc stays 020; exc=1 with stall=1 -> pc=F00, epc=020, redirect=1.
REQ-043 pc=FFF sequential -> pc=000, no redirect; jr_target=123 with jump=1 -> pc=123 (jr wins).
REQ-044 halt=1 at pc=030 -> halted=1, fetch_valid=0, pc=030 held; exc=1 later -> no change; clr_n=0 -> BOOT, pc=000.
REQ-045 clr_n=0 during stall at pc=055 -> next pc=000, state BOOT, epc=000, redirect=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module  : pc_seq_pkg
// Brief   : Shared state encoding and default parameters for the PC sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    localparam int          PC_W_DEF     = 12;
    localparam logic [11:0] EXC_VEC_DEF  = 12'hF00;
    localparam logic [11:0] RESET_PC_DEF = 12'h000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module  : pc_reg
// Brief   : PC storage register with load enable and synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg
    import pc_seq_pkg::*;
#(
    parameter int             PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_d,
    output logic [PC_W-1:0] o_q
);

    logic [PC_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_q <= RESET_PC;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Brief   : Program-counter sequencer with BOOT/RUN/HALT control and next-PC mux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(EXC_VEC_DEF),
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_offset,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    input  logic            exc,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] epc,
    output logic            fetch_valid,
    output logic            redirect,
    output logic            halted
);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [PC_W-1:0] r_epc;
    logic            r_redirect;

    logic [PC_W-1:0] w_pc;
    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_pc_load;
    logic            w_epc_load;
    logic            w_redirect_nxt;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_load (w_pc_load),
        .i_d    (w_pc_nxt),
        .o_q    (w_pc)
    );

    assign w_pc_plus1 = w_pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state    <= ST_BOOT;
            r_epc      <= '0;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_redirect <= w_redirect_nxt;
            if (w_epc_load) begin
                r_epc <= w_pc;
            end
        end
    end

    // Priority in RUN: exc > stall > halt > jr > jump > br_taken > sequential.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = w_pc;
        w_pc_load      = 1'b0;
        w_epc_load     = 1'b0;
        w_redirect_nxt = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (exc) begin
                    w_pc_nxt       = EXC_VEC;
                    w_pc_load      = 1'b1;
                    w_epc_load     = 1'b1;
                    w_redirect_nxt = 1'b1;
                end else if (stall) begin
                    w_pc_load = 1'b0;
                end else if (halt) begin
                    w_state_nxt = ST_HALT;
                end else if (jr) begin
                    w_pc_nxt       = jr_target;
                    w_pc_load      = 1'b1;
                    w_redirect_nxt = 1'b1;
                end else if (jump) begin
                    w_pc_nxt       = jump_target;
                    w_pc_load      = 1'b1;
                    w_redirect_nxt = 1'b1;
                end else if (br_taken) begin
                    w_pc_nxt       = w_pc_plus1 + br_offset;
                    w_pc_load      = 1'b1;
                    w_redirect_nxt = 1'b1;
                end else begin
                    w_pc_nxt  = w_pc_plus1;
                    w_pc_load = 1'b1;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign pc          = w_pc;
    assign pc_plus1    = w_pc_plus1;
    assign epc         = r_epc;
    assign redirect    = r_redirect;
    assign fetch_valid = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module  : tb_pc_sequencer
// Brief   : Self-checking bench: behavioural model plus directed literal checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk;
    logic        clr_n;
    logic        stall;
    logic        br_taken;
    logic [11:0] br_offset;
    logic        jump;
    logic [11:0] jump_target;
    logic        jr;
    logic [11:0] jr_target;
    logic        exc;
    logic        halt;
    logic [11:0] pc;
    logic [11:0] pc_plus1;
    logic [11:0] epc;
    logic        fetch_valid;
    logic        redirect;
    logic        halted;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jump        (jump),
        .jump_target (jump_target),
        .jr          (jr),
        .jr_target   (jr_target),
        .exc         (exc),
        .halt        (halt),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .epc         (epc),
        .fetch_valid (fetch_valid),
        .redirect    (redirect),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = booting, 1 = running, 2 = halted.
    int          m_mode;
    logic [11:0] m_pc;
    logic [11:0] m_epc;
    logic        m_redir;
    bit          m_known = 1'b0;

    always @(posedge clk) begin
        if (!clr_n) begin
            m_mode  = 0;
            m_pc    = 12'h000;
            m_epc   = 12'h000;
            m_redir = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            m_redir = 1'b0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (exc) begin
                    m_epc   = m_pc;
                    m_pc    = 12'hF00;
                    m_redir = 1'b1;
                end else if (stall) begin
                    m_pc = m_pc;
                end else if (halt) begin
                    m_mode = 2;
                end else if (jr) begin
                    m_pc    = jr_target;
                    m_redir = 1'b1;
                end else if (jump) begin
                    m_pc    = jump_target;
                    m_redir = 1'b1;
                end else if (br_taken) begin
                    m_pc    = 12'((int'(m_pc) + 1 + int'(br_offset)) % 4096);
                    m_redir = 1'b1;
                end else begin
                    m_pc = 12'((int'(m_pc) + 1) % 4096);
                end
            end
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            check("model_pc",       pc,                  m_pc);
            check("model_pc_plus1", pc_plus1,            12'((int'(m_pc) + 1) % 4096));
            check("model_epc",      epc,                 m_epc);
            check("model_fv",       {11'd0, fetch_valid}, {11'd0, m_mode == 1});
            check("model_halted",   {11'd0, halted},      {11'd0, m_mode == 2});
            check("model_redirect", {11'd0, redirect},    {11'd0, m_redir});
        end
    end

    task automatic idle();
        clr_n = 1'b1; stall = 1'b0; br_taken = 1'b0; br_offset = 12'h000;
        jump = 1'b0; jump_target = 12'h000; jr = 1'b0; jr_target = 12'h000;
        exc = 1'b0; halt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic goto(input logic [11:0] target);
        idle();
        jump = 1'b1; jump_target = target;
        tick();
        idle();
    endtask

    initial begin
        idle();
        clr_n = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, 12'h000);
        check("rst_pc_plus1", pc_plus1, 12'h001);
        check("rst_fv", {11'd0, fetch_valid}, 12'h000);
        check("rst_halted", {11'd0, halted}, 12'h000);
        check("rst_epc", epc, 12'h000);
        check("rst_redirect", {11'd0, redirect}, 12'h000);

        clr_n = 1'b1;
        tick();
        check("boot_exit_pc", pc, 12'h000);
        check("boot_exit_fv", {11'd0, fetch_valid}, 12'h001);
        tick(); check("seq_pc1", pc, 12'h001);
        tick(); check("seq_pc2", pc, 12'h002);
        tick(); check("seq_pc3", pc, 12'h003);

        goto(12'h010);
        check("jump_redirect", {11'd0, redirect}, 12'h001);
        br_taken = 1'b1; br_offset = 12'hFFE;
        tick();
        check("br_back_pc", pc, 12'h00F);
        check("br_back_redirect", {11'd0, redirect}, 12'h001);
        idle();
        tick();
        check("br_after_redirect", {11'd0, redirect}, 12'h000);
        jump = 1'b1; jump_target = 12'h0A0; br_taken = 1'b1; br_offset = 12'h005;
        tick();
        check("jump_over_br_pc", pc, 12'h0A0);

        goto(12'h020);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 12'h020);
            check("stall_redirect", {11'd0, redirect}, 12'h000);
        end
        exc = 1'b1; halt = 1'b1;
        tick();
        check("exc_pc", pc, 12'hF00);
        check("exc_epc", epc, 12'h020);
        check("exc_redirect", {11'd0, redirect}, 12'h001);
        idle();

        goto(12'hFFF);
        tick();
        check("wrap_pc", pc, 12'h000);
        check("wrap_redirect", {11'd0, redirect}, 12'h000);
        jr = 1'b1; jr_target = 12'h123; jump = 1'b1; jump_target = 12'h456;
        tick();
        check("jr_wins_pc", pc, 12'h123);
        idle();

        goto(12'h030);
        halt = 1'b1;
        tick();
        check("halt_halted", {11'd0, halted}, 12'h001);
        check("halt_fv", {11'd0, fetch_valid}, 12'h000);
        check("halt_pc", pc, 12'h030);
        halt = 1'b0; exc = 1'b1; jump = 1'b1; jump_target = 12'h777;
        tick();
        tick();
        check("halt_exc_pc", pc, 12'h030);
        check("halt_exc_epc", epc, 12'h020);
        check("halt_exc_halted", {11'd0, halted}, 12'h001);
        clr_n = 1'b0;
        tick();
        check("halt_rst_pc", pc, 12'h000);
        check("halt_rst_halted", {11'd0, halted}, 12'h000);
        check("halt_rst_fv", {11'd0, fetch_valid}, 12'h000);
        idle();
        tick();

        goto(12'h055);
        exc = 1'b1;
        tick();
        check("exc2_epc", epc, 12'h055);
        goto(12'h055);
        stall = 1'b1;
        tick();
        check("stall2_pc", pc, 12'h055);
        clr_n = 1'b0;
        tick();
        check("stall_rst_pc", pc, 12'h000);
        check("stall_rst_epc", epc, 12'h000);
        check("stall_rst_redirect", {11'd0, redirect}, 12'h000);
        check("stall_rst_fv", {11'd0, fetch_valid}, 12'h000);
        idle();
        tick();
        tick();
        check("post_rst_pc", pc, 12'h001);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
